// File: rtl/vx_tensor_result_sequencer_pkg.sv
// Shared types and default geometry for the tensor-core result sequencer.
// The sequencer and its FIFOs import these defaults so that every level agrees on widths.
package VX_gpu_pkg;

   localparam int TC_NUM_LANES  = 4;
   localparam int TC_LANE_WORDS = 16;
   localparam int TC_NUM_SUB    = 2;
   localparam int TC_WORDW      = 32;
   localparam int TC_META_W     = 64;
   localparam int TC_DEPTH      = 4;
   localparam int TC_META_DEPTH = 8;

   // Index width that stays legal (>=1 bit) even when only one value exists.
   function automatic int tc_clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int TC_WPL      = TC_LANE_WORDS / TC_NUM_SUB;
   localparam int TC_SUB_BITS = tc_clog2_min1(TC_NUM_SUB);

   typedef logic [TC_META_W-1:0] tc_meta_t;

endpackage

// File: rtl/vx_tensor_result_sequencer_lane_fifo.sv
// Registered FIFO with a combinational head view, used for every result lane and for metadata.
// Pointers carry one wrap bit so full and empty are distinguished without a separate counter.
module vx_tensor_lane_fifo
   import VX_gpu_pkg::*;
#(
   parameter int W     = TC_WORDW,
   parameter int DEPTH = TC_DEPTH
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         empty,
   output logic         full,
   output logic [W-1:0] head
);

   localparam int AW = tc_clog2_min1(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: occupancy is defined entirely by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/vx_tensor_result_sequencer.sv
// Pairs per-lane D-tile results with dispatch metadata and streams each complete result
// as NUM_SUB commit beats; lanes may arrive skewed, a result commits once every lane has it.
module vx_tensor_result_sequencer
   import VX_gpu_pkg::*;
#(
   parameter int NUM_LANES  = TC_NUM_LANES,
   parameter int LANE_WORDS = TC_LANE_WORDS,
   parameter int NUM_SUB    = TC_NUM_SUB,
   parameter int WORDW      = TC_WORDW,
   parameter int META_W     = TC_META_W,
   parameter int DEPTH      = TC_DEPTH,
   parameter int META_DEPTH = TC_META_DEPTH
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       flush,
   input  logic                                       meta_valid,
   output logic                                       meta_ready,
   input  logic [META_W-1:0]                          meta_data,
   input  logic [NUM_LANES-1:0]                       lane_valid,
   output logic [NUM_LANES-1:0]                       lane_ready,
   input  logic [NUM_LANES*LANE_WORDS*WORDW-1:0]      lane_data,
   output logic                                       commit_valid,
   input  logic                                       commit_ready,
   output logic [META_W-1:0]                          commit_meta,
   output logic [NUM_LANES*(LANE_WORDS/NUM_SUB)*WORDW-1:0] commit_data,
   output logic [tc_clog2_min1(NUM_SUB)-1:0]          commit_sub,
   output logic                                       commit_last,
   output logic                                       busy
);

   localparam int WPL        = LANE_WORDS / NUM_SUB;
   localparam int SUB_BITS   = tc_clog2_min1(NUM_SUB);
   localparam int LANE_W     = LANE_WORDS * WORDW;
   localparam int BEAT_WORDS = NUM_LANES * WPL;
   localparam int BEAT_W     = BEAT_WORDS * WORDW;
   localparam logic [SUB_BITS-1:0] SUB_MAX = SUB_BITS'(NUM_SUB - 1);
   localparam logic [SUB_BITS-1:0] SUB_ONE = SUB_BITS'(1);

   // Assertion is immediate; release is retimed to clk so no flop sees it mid-cycle.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   logic [SUB_BITS-1:0]  sub_q, sub_d;
   logic                 meta_empty, meta_full, meta_push;
   logic [META_W-1:0]    meta_head;
   logic [NUM_LANES-1:0] lane_empty, lane_full, lane_push;
   logic [LANE_W-1:0]    lane_head [NUM_LANES];
   logic [BEAT_W-1:0]    beat_opt [NUM_SUB];
   logic                 sub_last;
   logic                 fire;
   logic                 pop_all;

   assign meta_push = meta_valid && !meta_full;

   vx_tensor_lane_fifo #(
      .W     (META_W),
      .DEPTH (META_DEPTH)
   ) u_meta_fifo (
      .clk   (clk),
      .reset (rst_int_n),
      .flush (flush),
      .push  (meta_push),
      .pop   (pop_all),
      .din   (meta_data),
      .empty (meta_empty),
      .full  (meta_full),
      .head  (meta_head)
   );

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_push[gi]  = lane_valid[gi] && !lane_full[gi];
      assign lane_ready[gi] = !lane_full[gi];

      vx_tensor_lane_fifo #(
         .W     (LANE_W),
         .DEPTH (DEPTH)
      ) u_lane_fifo (
         .clk   (clk),
         .reset (rst_int_n),
         .flush (flush),
         .push  (lane_push[gi]),
         .pop   (pop_all),
         .din   (lane_data[gi*LANE_W +: LANE_W]),
         .empty (lane_empty[gi]),
         .full  (lane_full[gi]),
         .head  (lane_head[gi])
      );
   end

   // Every candidate beat is wired statically; sub_q only selects among them.
   for (genvar gi = 0; gi < NUM_SUB; gi++) begin : g_sub
      for (genvar gj = 0; gj < BEAT_WORDS; gj++) begin : g_word
         localparam int SRC_LANE = gj / WPL;
         localparam int SRC_WORD = gi * WPL + (gj % WPL);
         assign beat_opt[gi][gj*WORDW +: WORDW] = lane_head[SRC_LANE][SRC_WORD*WORDW +: WORDW];
      end
   end

   assign sub_last     = (sub_q == SUB_MAX);
   assign commit_valid = !flush && !meta_empty && !(|lane_empty);
   assign fire         = commit_valid && commit_ready;
   assign pop_all      = fire && sub_last;

   assign meta_ready  = !meta_full;
   assign commit_meta = meta_head;
   assign commit_data = beat_opt[sub_q];
   assign commit_sub  = sub_q;
   assign commit_last = sub_last;
   assign busy        = !meta_empty || !(&lane_empty);

   always_comb begin
      sub_d = sub_q;
      if (flush)         sub_d = '0;
      else if (pop_all)  sub_d = '0;
      else if (fire)     sub_d = sub_q + SUB_ONE;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) sub_q <= '0;
      else            sub_q <= sub_d;
   end

endmodule

// File: tb/tb_vx_tensor_result_sequencer.sv
// Directed-then-random bench for the tensor result sequencer, checked each cycle against
// a queue-based model of metadata, per-lane results and the beat position within a result.
module tb_vx_tensor_result_sequencer;

   localparam int NL  = 4;
   localparam int LW  = 16;
   localparam int NS  = 2;
   localparam int WW  = 32;
   localparam int MW  = 64;
   localparam int D   = 4;
   localparam int MD  = 8;
   localparam int WPL = LW / NS;
   localparam int RW  = LW * WW;
   localparam int BW  = NL * WPL * WW;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            flush = 1'b0;
   logic            meta_valid = 1'b0;
   logic            meta_ready;
   logic [MW-1:0]   meta_data = '0;
   logic [NL-1:0]   lane_valid = '0;
   logic [NL-1:0]   lane_ready;
   logic [NL*RW-1:0] lane_data = '0;
   logic            commit_valid;
   logic            commit_ready = 1'b0;
   logic [MW-1:0]   commit_meta;
   logic [BW-1:0]   commit_data;
   logic [0:0]      commit_sub;
   logic            commit_last;
   logic            busy;

   vx_tensor_result_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .meta_valid   (meta_valid),
      .meta_ready   (meta_ready),
      .meta_data    (meta_data),
      .lane_valid   (lane_valid),
      .lane_ready   (lane_ready),
      .lane_data    (lane_data),
      .commit_valid (commit_valid),
      .commit_ready (commit_ready),
      .commit_meta  (commit_meta),
      .commit_data  (commit_data),
      .commit_sub   (commit_sub),
      .commit_last  (commit_last),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef logic [RW-1:0] res_t;
   typedef res_t res_q_t[$];

   res_q_t        lane_q [NL];
   logic [MW-1:0] meta_q[$];
   int            beat_no;
   int            n_cmp = 0;
   int            n_err = 0;

   task automatic cmp(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit all_lanes_have();
      bit ok;
      ok = 1'b1;
      for (int l = 0; l < NL; l++) if (lane_q[l].size() == 0) ok = 1'b0;
      return ok;
   endfunction

   function automatic bit model_valid();
      return !flush && (meta_q.size() > 0) && all_lanes_have();
   endfunction

   task automatic model_clear();
      meta_q.delete();
      for (int l = 0; l < NL; l++) lane_q[l].delete();
      beat_no = 0;
   endtask

   task automatic check();
      logic [NL-1:0] exp_rdy;
      logic [BW-1:0] exp_data;
      bit            exp_busy;
      bit            ev;
      res_t          r;
      ev       = model_valid();
      exp_busy = (meta_q.size() > 0);
      for (int l = 0; l < NL; l++) begin
         exp_rdy[l] = (lane_q[l].size() < D);
         if (lane_q[l].size() > 0) exp_busy = 1'b1;
      end
      cmp("lane_ready", BW'(lane_ready), BW'(exp_rdy));
      cmp("meta_ready", BW'(meta_ready), BW'(meta_q.size() < MD));
      cmp("busy", BW'(busy), BW'(exp_busy));
      cmp("commit_valid", BW'(commit_valid), BW'(ev));
      cmp("commit_sub", BW'(commit_sub), BW'(beat_no));
      cmp("commit_last", BW'(commit_last), BW'(beat_no == NS - 1));
      if (ev) begin
         for (int j = 0; j < NL * WPL; j++) begin
            r = lane_q[j / WPL][0];
            exp_data[j*WW +: WW] = r[(beat_no * WPL + j % WPL) * WW +: WW];
         end
         cmp("commit_data", commit_data, exp_data);
         cmp("commit_meta", BW'(commit_meta), BW'(meta_q[0]));
      end
   endtask

   task automatic model_edge();
      bit   fire;
      bit   mp;
      bit   lp [NL];
      res_t r;
      if (!reset || flush) begin
         model_clear();
         return;
      end
      fire = model_valid() && commit_ready;
      mp   = meta_valid && (meta_q.size() < MD);
      for (int l = 0; l < NL; l++) lp[l] = lane_valid[l] && (lane_q[l].size() < D);
      if (fire) begin
         if (beat_no == NS - 1) begin
            beat_no = 0;
            void'(meta_q.pop_front());
            for (int l = 0; l < NL; l++) void'(lane_q[l].pop_front());
         end else begin
            beat_no++;
         end
      end
      if (mp) meta_q.push_back(meta_data);
      for (int l = 0; l < NL; l++) begin
         if (lp[l]) begin
            r = lane_data[l*RW +: RW];
            lane_q[l].push_back(r);
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      check();
      @(posedge clk);
      model_edge();
      #1;
      meta_valid = 1'b0;
      lane_valid = '0;
      flush      = 1'b0;
   endtask

   function automatic res_t rnd_res();
      res_t r;
      for (int w = 0; w < LW; w++) r[w*WW +: WW] = $urandom;
      return r;
   endfunction

   task automatic set_lane(input int l, input res_t r);
      lane_data[l*RW +: RW] = r;
      lane_valid[l] = 1'b1;
   endtask

   task automatic push_meta(input logic [MW-1:0] m);
      meta_data  = m;
      meta_valid = 1'b1;
   endtask

   initial begin
      res_t r;
      model_clear();

      // Reset state
      repeat (3) cyc();
      reset = 1'b1;
      repeat (3) cyc();

      // 1: one result from a tagged pattern, two beats
      push_meta(64'h00A0_0000_0000_0000);
      cyc();
      for (int l = 0; l < NL; l++) begin
         for (int w = 0; w < LW; w++) r[w*WW +: WW] = 32'((l << 8) | w);
         set_lane(l, r);
      end
      cyc();
      commit_ready = 1'b1;
      repeat (4) cyc();

      // 2: lane 3 trails the others by 10 cycles for 4 results
      for (int c = 0; c < 26; c++) begin
         if (c < 4) push_meta({32'hB0B0_0000, 32'(c)});
         if (c < 8) for (int l = 0; l < 3; l++) set_lane(l, rnd_res());
         if (c >= 10 && c < 14) set_lane(3, rnd_res());
         cyc();
      end

      // 3: consumer stalls for 5 cycles on beat 0
      commit_ready = 1'b0;
      push_meta({$urandom, $urandom});
      for (int l = 0; l < NL; l++) set_lane(l, rnd_res());
      cyc();
      repeat (5) cyc();
      commit_ready = 1'b1;
      repeat (3) cyc();

      // 4: metadata fills with no lane data; refused push during last-beat pop
      for (int c = 0; c < 9; c++) begin
         push_meta({32'hC0C0_0000, 32'(c)});
         cyc();
      end
      for (int l = 0; l < NL; l++) set_lane(l, rnd_res());
      cyc();
      for (int c = 0; c < 4; c++) begin
         push_meta({32'hC1C1_0000, 32'(c)});
         cyc();
      end

      // 5: flush with a result half-committed and three results buffered
      commit_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         for (int l = 0; l < NL; l++) set_lane(l, rnd_res());
         cyc();
      end
      commit_ready = 1'b1;
      cyc();
      commit_ready = 1'b0;
      flush = 1'b1;
      cyc();
      repeat (2) cyc();

      // 6: asynchronous reset between clock edges
      push_meta({$urandom, $urandom});
      for (int l = 0; l < NL; l++) set_lane(l, rnd_res());
      cyc();
      cyc();
      #2;
      reset = 1'b0;
      #1;
      cmp("async_rst_valid", BW'(commit_valid), BW'(1'b0));
      cmp("async_rst_busy", BW'(busy), BW'(1'b0));
      model_clear();
      #3;
      reset = 1'b1;
      repeat (4) cyc();
      push_meta(64'h0000_0000_0000_00E1);
      for (int l = 0; l < NL; l++) set_lane(l, rnd_res());
      cyc();
      commit_ready = 1'b1;
      repeat (4) cyc();

      // Randomized traffic with occasional flush and backpressure
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) != 0) push_meta({$urandom, $urandom});
         for (int l = 0; l < NL; l++) if ($urandom_range(0, 3) != 0) set_lane(l, rnd_res());
         commit_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 79) == 0);
         cyc();
      end
      commit_ready = 1'b1;
      repeat (40) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
